// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions.
//   XLEN            - architectural register / address width
//   NOP_INSTR       - addi x0,x0,0, driven into IF/ID on bubbles
//   fetch_state_t   - instruction-fetch FSM states
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle.
//   req    - fetch request (master -> slave)
//   addr   - word-aligned fetch address (master -> slave)
//   gnt    - request accepted this cycle (slave -> master)
//   rvalid - response data valid, one per granted request (slave -> master)
//   rdata  - returned instruction word (slave -> master)
interface fetch_stage_if import riscv_pkg::*; ();

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the PC, issues
// at most one outstanding instruction-memory request, applies hazard stalls
// and EX redirects, and presents an instruction (or NOP bubble) to IF/ID.
//
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   enable               - hazard-unit advance (0 = stall)
//   redirect_valid/_pc   - EX branch-taken / jump target
//   imem                 - instruction-memory interface (master side)
//   instr_if, pc_if,
//   pc_plus4_if          - instruction, its PC and PC+4 towards IF/ID
//   instr_valid_if       - instr_if is a real fetched instruction
//   fetch_misaligned_if  - redirect target was not word-aligned
//
// Build option: define FETCH_ALIGN_CHECK_EN to flag misaligned redirect
// targets instead of silently aligning them.
module fetch_stage import riscv_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            enable,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    fetch_stage_if.master   imem,
    output logic [XLEN-1:0] instr_if,
    output logic [XLEN-1:0] pc_if,
    output logic [XLEN-1:0] pc_plus4_if,
    output logic            instr_valid_if,
    output logic            fetch_misaligned_if
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next4;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] ibuf;
    logic            kill;
    logic            misaligned;

    assign pc_next4 = pc + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target = redirect_pc;

    // Sticky until the next redirect; an aligned redirect clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            misaligned <= 1'b0;
        end else if (redirect_valid) begin
            misaligned <= |redirect_pc[1:0];
        end
    end
`else
    assign target     = redirect_pc & ~32'h3;
    assign misaligned = 1'b0;
`endif

    assign fetch_misaligned_if = misaligned;
    assign pc_if               = pc;
    assign pc_plus4_if         = pc_next4;

    // Outputs are combinational so returned data reaches IF/ID in the same
    // cycle and the next request can be issued back-to-back with it.
    always_comb begin
        imem.req       = 1'b0;
        imem.addr      = pc;
        instr_if       = NOP_INSTR;
        instr_valid_if = 1'b0;
        if (!redirect_valid) begin
            unique case (state)
                FETCH: begin
                    imem.req = !misaligned;
                end
                WAIT: begin
                    if (imem.rvalid && !kill) begin
                        instr_if       = imem.rdata;
                        instr_valid_if = 1'b1;
                        if (enable) begin
                            imem.req  = 1'b1;
                            imem.addr = pc_next4;
                        end
                    end
                end
                HOLD: begin
                    instr_if       = ibuf;
                    instr_valid_if = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= FETCH;
            pc    <= RESET_PC;
            kill  <= 1'b0;
            ibuf  <= '0;
        end else if (redirect_valid) begin
            pc <= target;
            // A request still in flight must have its response dropped
            // before the target is fetched.
            if (state == WAIT && !imem.rvalid) begin
                kill  <= 1'b1;
                state <= WAIT;
            end else begin
                kill  <= 1'b0;
                state <= FETCH;
            end
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem.req && imem.gnt) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem.rvalid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= FETCH;
                        end else if (enable) begin
                            pc    <= pc_next4;
                            state <= imem.gnt ? WAIT : FETCH;
                        end else begin
                            ibuf  <= imem.rdata;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (enable) begin
                        pc    <= pc_next4;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr_if, pc_if, pc_plus4_if;
    logic        instr_valid_if, fetch_misaligned_if;

    int checks = 0;
    int errors = 0;

    fetch_stage_if imem();

    fetch_stage #(.RESET_PC(32'h0)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .enable              (enable),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .imem                (imem),
        .instr_if            (instr_if),
        .pc_if               (pc_if),
        .pc_plus4_if         (pc_plus4_if),
        .instr_valid_if      (instr_valid_if),
        .fetch_misaligned_if (fetch_misaligned_if)
    );

    always #5 clk = ~clk;

    // Memory model: always grants, answers lat cycles after the grant.
    int          lat = 1;
    logic        pending;
    int          cnt;
    logic [31:0] pend_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8) return 32'h00A0_0093;
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem.gnt    = imem.req;
    assign imem.rvalid = pending && (cnt == 0);
    assign imem.rdata  = imem.rvalid ? mem_word(pend_addr) : 32'hDEAD_BEEF;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending   <= 1'b0;
            cnt       <= 0;
            pend_addr <= '0;
        end else begin
            if (imem.rvalid) pending <= 1'b0;
            if (imem.gnt) begin
                pending   <= 1'b1;
                cnt       <= lat - 1;
                pend_addr <= imem.addr;
            end else if (pending && cnt != 0) begin
                cnt <= cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic out_nop(input string tag);
        check({tag, "_instr"}, instr_if, NOP_INSTR);
        check({tag, "_valid"}, {31'b0, instr_valid_if}, 32'd0);
    endtask

    task automatic out_valid(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        check({tag, "_valid"}, {31'b0, instr_valid_if}, 32'd1);
        check({tag, "_pc"}, pc_if, pc);
        check({tag, "_instr"}, instr_if, ins);
    endtask

    task automatic req_is(input string tag, input logic r, input logic [31:0] a);
        check({tag, "_req"}, {31'b0, imem.req}, {31'b0, r});
        if (r) check({tag, "_addr"}, imem.addr, a);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        out_nop("rst");
        req_is("rst", 1'b1, 32'h0);
        check("rst_pc", pc_if, 32'h0);
        check("rst_pc4", pc_plus4_if, 32'h4);
        check("rst_mis", {31'b0, fetch_misaligned_if}, 32'd0);

        // Free run, 1-cycle memory
        @(negedge clk); resetn = 1'b1; #1;
        out_nop("a"); req_is("a", 1'b1, 32'h0);
        @(negedge clk); #1;
        out_valid("b", 32'h0, 32'h5A5A_0000); req_is("b", 1'b1, 32'h4);
        @(negedge clk); #1;
        out_valid("c", 32'h4, 32'h5A5A_0004); req_is("c", 1'b1, 32'h8);

        // Stall as data for pc 8 returns
        @(negedge clk); enable = 1'b0; #1;
        out_valid("d", 32'h8, 32'h00A0_0093); req_is("d", 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            out_valid("hold", 32'h8, 32'h00A0_0093); req_is("hold", 1'b0, 32'h0);
        end
        @(negedge clk); enable = 1'b1; #1;
        out_valid("h", 32'h8, 32'h00A0_0093); req_is("h", 1'b0, 32'h0);
        @(negedge clk); lat = 3; #1;
        out_nop("i"); req_is("i", 1'b1, 32'hC);

        // Redirect while waiting on a 3-cycle memory
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        out_nop("j"); req_is("j", 1'b0, 32'h0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        out_nop("k"); req_is("k", 1'b0, 32'h0); check("k_pc", pc_if, 32'h100);
        @(negedge clk); #1;
        out_nop("l_stale"); req_is("l", 1'b0, 32'h0);
        @(negedge clk); #1;
        out_nop("m"); req_is("m", 1'b1, 32'h100); check("m_pc", pc_if, 32'h100);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            out_nop("nwait"); req_is("nwait", 1'b0, 32'h0);
        end
        @(negedge clk); enable = 1'b0; lat = 1; #1;
        out_valid("p", 32'h100, 32'h5A5A_0100); req_is("p", 1'b0, 32'h0);

        // Redirect concurrent with stall in HOLD
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
        out_nop("q"); req_is("q", 1'b0, 32'h0);
        @(negedge clk); redirect_valid = 1'b0; enable = 1'b1; #1;
        out_nop("r"); req_is("r", 1'b1, 32'h200); check("r_pc", pc_if, 32'h200);
        @(negedge clk); #1;
        out_valid("s", 32'h200, 32'h5A5A_0200); req_is("s", 1'b1, 32'h204);

        // PC wrap
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        out_nop("t"); req_is("t", 1'b0, 32'h0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        req_is("u", 1'b1, 32'hFFFF_FFFC);
        check("u_pc", pc_if, 32'hFFFF_FFFC); check("u_pc4", pc_plus4_if, 32'h0);
        @(negedge clk); #1;
        out_valid("v", 32'hFFFF_FFFC, 32'hA5A5_FFFC); req_is("v", 1'b1, 32'h0);

        // Misaligned redirect target
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
        out_nop("w"); req_is("w", 1'b0, 32'h0);
        @(negedge clk); redirect_valid = 1'b0; #1;
`ifdef FETCH_ALIGN_CHECK_EN
        out_nop("x"); req_is("x", 1'b0, 32'h0);
        check("x_mis", {31'b0, fetch_misaligned_if}, 32'd1);
        check("x_pc", pc_if, 32'h102);
        @(negedge clk); #1;
        out_nop("x2"); req_is("x2", 1'b0, 32'h0);
        check("x2_mis", {31'b0, fetch_misaligned_if}, 32'd1);
`else
        out_nop("x"); req_is("x", 1'b1, 32'h100);
        check("x_mis", {31'b0, fetch_misaligned_if}, 32'd0);
        check("x_pc", pc_if, 32'h100);
        @(negedge clk); #1;
        out_valid("x2", 32'h100, 32'h5A5A_0100); req_is("x2", 1'b1, 32'h104);
`endif
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h104; #1;
        out_nop("y"); req_is("y", 1'b0, 32'h0);
        @(negedge clk); redirect_valid = 1'b0; #1;
        out_nop("z"); req_is("z", 1'b1, 32'h104);
        check("z_mis", {31'b0, fetch_misaligned_if}, 32'd0);
        check("z_pc", pc_if, 32'h104);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
